point_pickup_scheduler: RTL and testbench

Sequences the collectible-point lifecycle for the two-player game: requests a new point from the random point generator, holds it on screen, and detects pickup by either player. It arbitrates simultaneous pickups, updates per-player scores, and enforces a respawn cooldown before the next request. It sits between the player movement blocks, the random point generator and the score/draw logic.

---
 rtl/point_pickup_scheduler.sv | 207 ++++++++++++++++++++
 tb/tb_point_pickup_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/point_pickup_scheduler.sv
// Collectible-point lifecycle: spawn request, on-screen hold, two-player pickup with
// alternating tie priority, saturating scores and respawn cooldown. Optional POINT_TIMEOUT_EN adds point expiry.
module point_pickup_scheduler #(
    parameter int POINT_SIZE    = 8,
    parameter int PLAYER_SIZE   = 16,
    parameter int RESPAWN_DELAY = 32,
    parameter int SCORE_W       = 8,
    parameter int POINT_TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_active,
    input  logic               score_clr,
    input  logic [9:0]         player1_x,
    input  logic [9:0]         player1_y,
    input  logic [9:0]         player2_x,
    input  logic [9:0]         player2_y,
    output logic               spawn_req,
    input  logic               spawn_ack,
    input  logic [9:0]         spawn_x,
    input  logic [9:0]         spawn_y,
    output logic               point_visible,
    output logic [9:0]         point_x,
    output logic [9:0]         point_y,
    output logic               pickup_p1,
    output logic               pickup_p2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2
);

    localparam int CD_W = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY + 1) : 1;
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(RESPAWN_DELAY);
    localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);
    localparam logic [10:0]     HIT_R   = 11'(POINT_SIZE + PLAYER_SIZE);
    localparam bit              NO_COOL = (RESPAWN_DELAY == 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_ACTIVE,
        S_COOL
    } state_t;

    state_t             r_state, w_state_nxt;
    logic               r_spawn_req, w_spawn_req_nxt;
    logic               r_vis, w_vis_nxt;
    logic [9:0]         r_px, w_px_nxt;
    logic [9:0]         r_py, w_py_nxt;
    logic               r_pk1, w_pk1_nxt;
    logic               r_pk2, w_pk2_nxt;
    logic [SCORE_W-1:0] r_s1, w_s1_nxt;
    logic [SCORE_W-1:0] r_s2, w_s2_nxt;
    logic [CD_W-1:0]    r_cd, w_cd_nxt;
    // r_prio low: player 1 wins the next tie; high: player 2 does
    logic               r_prio, w_prio_nxt;
    logic               w_win1;
    logic               w_expire;

    function automatic logic [10:0] abs_diff11(input logic [9:0] a, input logic [9:0] b);
        if (a >= b)
            return {1'b0, a} - {1'b0, b};
        return {1'b0, b} - {1'b0, a};
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        if (&s)
            return s;
        return s + SCORE_W'(1);
    endfunction

    logic [10:0] w_dx1, w_dy1, w_dx2, w_dy2;
    logic        w_hit1, w_hit2;

    assign w_dx1  = abs_diff11(r_px, player1_x);
    assign w_dy1  = abs_diff11(r_py, player1_y);
    assign w_dx2  = abs_diff11(r_px, player2_x);
    assign w_dy2  = abs_diff11(r_py, player2_y);
    assign w_hit1 = (w_dx1 <= HIT_R) && (w_dy1 <= HIT_R);
    assign w_hit2 = (w_dx2 <= HIT_R) && (w_dy2 <= HIT_R);

`ifdef POINT_TIMEOUT_EN
    localparam int AGE_W = $clog2(POINT_TIMEOUT + 1);
    logic [AGE_W-1:0] r_age;

    always_ff @(posedge clk) begin
        if (!rst || r_state != S_ACTIVE)
            r_age <= '0;
        else
            r_age <= r_age + AGE_W'(1);
    end

    assign w_expire = (r_age == AGE_W'(POINT_TIMEOUT - 1));
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt     = r_state;
        w_spawn_req_nxt = 1'b0;
        w_vis_nxt       = 1'b0;
        w_px_nxt        = r_px;
        w_py_nxt        = r_py;
        w_pk1_nxt       = 1'b0;
        w_pk2_nxt       = 1'b0;
        w_s1_nxt        = r_s1;
        w_s2_nxt        = r_s2;
        w_cd_nxt        = r_cd;
        w_prio_nxt      = r_prio;
        w_win1          = 1'b0;

        if (!game_active) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt     = S_REQ;
                    w_spawn_req_nxt = 1'b1;
                end
                S_REQ: begin
                    if (r_spawn_req && spawn_ack) begin
                        w_px_nxt    = spawn_x;
                        w_py_nxt    = spawn_y;
                        w_vis_nxt   = 1'b1;
                        w_state_nxt = S_ACTIVE;
                    end else begin
                        w_spawn_req_nxt = 1'b1;
                    end
                end
                S_ACTIVE: begin
                    if (w_hit1 || w_hit2 || w_expire) begin
                        if (w_hit1 || w_hit2) begin
                            w_win1     = (w_hit1 && w_hit2) ? ~r_prio : w_hit1;
                            w_pk1_nxt  = w_win1;
                            w_pk2_nxt  = ~w_win1;
                            w_prio_nxt = w_win1;
                            if (w_win1)
                                w_s1_nxt = sat_inc(r_s1);
                            else
                                w_s2_nxt = sat_inc(r_s2);
                        end
                        w_cd_nxt = CD_LOAD;
                        if (NO_COOL) begin
                            w_state_nxt     = S_REQ;
                            w_spawn_req_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_COOL;
                        end
                    end else begin
                        w_vis_nxt = 1'b1;
                    end
                end
                S_COOL: begin
                    w_cd_nxt = r_cd - CD_ONE;
                    if (r_cd == CD_ONE) begin
                        w_state_nxt     = S_REQ;
                        w_spawn_req_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end

        // Clear beats a same-edge pickup increment
        if (score_clr) begin
            w_s1_nxt = '0;
            w_s2_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_spawn_req <= 1'b0;
            r_vis       <= 1'b0;
            r_px        <= '0;
            r_py        <= '0;
            r_pk1       <= 1'b0;
            r_pk2       <= 1'b0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_cd        <= '0;
            r_prio      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_spawn_req <= w_spawn_req_nxt;
            r_vis       <= w_vis_nxt;
            r_px        <= w_px_nxt;
            r_py        <= w_py_nxt;
            r_pk1       <= w_pk1_nxt;
            r_pk2       <= w_pk2_nxt;
            r_s1        <= w_s1_nxt;
            r_s2        <= w_s2_nxt;
            r_cd        <= w_cd_nxt;
            r_prio      <= w_prio_nxt;
        end
    end

    assign spawn_req     = r_spawn_req;
    assign point_visible = r_vis;
    assign point_x       = r_px;
    assign point_y       = r_py;
    assign pickup_p1     = r_pk1;
    assign pickup_p2     = r_pk2;
    assign score1        = r_s1;
    assign score2        = r_s2;

endmodule

// File: tb/tb_point_pickup_scheduler.sv
// Bench for point_pickup_scheduler: default instance plus a SCORE_W=2 / zero-cooldown instance,
// directed scenarios then randomized traffic, all checked against a behavioural model every cycle.
module tb_point_pickup_scheduler;

    logic       clk = 1'b0;
    logic       rst, game_active, score_clr;
    logic [9:0] player1_x, player1_y, player2_x, player2_y;
    logic [9:0] spawn_x, spawn_y;
    logic       ack_a, ack_b;

    logic       a_req, a_vis, a_pk1, a_pk2;
    logic [9:0] a_px, a_py;
    logic [7:0] a_s1, a_s2;
    logic       b_req, b_vis, b_pk1, b_pk2;
    logic [9:0] b_px, b_py;
    logic [1:0] b_s1, b_s2;

    always #5 clk = ~clk;

    point_pickup_scheduler u_dut_a (
        .clk(clk), .rst(rst), .game_active(game_active), .score_clr(score_clr),
        .player1_x(player1_x), .player1_y(player1_y), .player2_x(player2_x), .player2_y(player2_y),
        .spawn_req(a_req), .spawn_ack(ack_a), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .point_visible(a_vis), .point_x(a_px), .point_y(a_py),
        .pickup_p1(a_pk1), .pickup_p2(a_pk2), .score1(a_s1), .score2(a_s2)
    );

    point_pickup_scheduler #(.SCORE_W(2), .RESPAWN_DELAY(0)) u_dut_b (
        .clk(clk), .rst(rst), .game_active(game_active), .score_clr(score_clr),
        .player1_x(player1_x), .player1_y(player1_y), .player2_x(player2_x), .player2_y(player2_y),
        .spawn_req(b_req), .spawn_ack(ack_b), .spawn_x(spawn_x), .spawn_y(spawn_y),
        .point_visible(b_vis), .point_x(b_px), .point_y(b_py),
        .pickup_p1(b_pk1), .pickup_p2(b_pk2), .score1(b_s1), .score2(b_s2)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: one entry per instance. Phase 0=idle, 1=requesting, 2=point live, 3=cooling.
    localparam int REACH = 24;
    int m_phase[2], m_left[2], m_px[2], m_py[2], m_s1[2], m_s2[2];
    bit m_req[2], m_vis[2], m_pk1[2], m_pk2[2], m_p2_first[2];
    int m_delay[2] = '{32, 0};
    int m_max[2]   = '{255, 3};

    function automatic bit touches(input int px, input int py, input int qx, input int qy);
        int dx, dy;
        dx = (px > qx) ? px - qx : qx - px;
        dy = (py > qy) ? py - qy : qy - py;
        return (dx <= REACH) && (dy <= REACH);
    endfunction

    task automatic award(input int d, input bit to_p1);
        if (to_p1) begin
            m_pk1[d] = 1;
            if (m_s1[d] < m_max[d]) m_s1[d]++;
        end else begin
            m_pk2[d] = 1;
            if (m_s2[d] < m_max[d]) m_s2[d]++;
        end
        m_p2_first[d] = to_p1;
    endtask

    task automatic model_step(input int d, input bit ack);
        bit h1, h2;
        m_pk1[d] = 0;
        m_pk2[d] = 0;
        if (!rst) begin
            m_phase[d] = 0; m_req[d] = 0; m_vis[d] = 0; m_px[d] = 0; m_py[d] = 0;
            m_s1[d] = 0; m_s2[d] = 0; m_left[d] = 0; m_p2_first[d] = 0;
            return;
        end
        h1 = touches(m_px[d], m_py[d], player1_x, player1_y);
        h2 = touches(m_px[d], m_py[d], player2_x, player2_y);
        if (!game_active) begin
            m_phase[d] = 0; m_req[d] = 0; m_vis[d] = 0;
        end else if (m_phase[d] == 0) begin
            m_phase[d] = 1; m_req[d] = 1;
        end else if (m_phase[d] == 1) begin
            if (ack) begin
                m_px[d] = spawn_x; m_py[d] = spawn_y;
                m_phase[d] = 2; m_req[d] = 0; m_vis[d] = 1;
            end
        end else if (m_phase[d] == 2) begin
            if (h1 || h2) begin
                award(d, (h1 && h2) ? !m_p2_first[d] : h1);
                m_vis[d] = 0;
                if (m_delay[d] == 0) begin
                    m_phase[d] = 1; m_req[d] = 1;
                end else begin
                    m_phase[d] = 3; m_left[d] = m_delay[d];
                end
            end
        end else begin
            if (m_left[d] == 1) begin
                m_phase[d] = 1; m_req[d] = 1;
            end
            m_left[d]--;
        end
        if (score_clr) begin
            m_s1[d] = 0; m_s2[d] = 0;
        end
    endtask

    task automatic compare_all();
        chk("a_spawn_req", a_req, m_req[0]);
        chk("a_visible",   a_vis, m_vis[0]);
        chk("a_point_x",   a_px,  m_px[0]);
        chk("a_point_y",   a_py,  m_py[0]);
        chk("a_pickup_p1", a_pk1, m_pk1[0]);
        chk("a_pickup_p2", a_pk2, m_pk2[0]);
        chk("a_score1",    a_s1,  m_s1[0]);
        chk("a_score2",    a_s2,  m_s2[0]);
        chk("b_spawn_req", b_req, m_req[1]);
        chk("b_visible",   b_vis, m_vis[1]);
        chk("b_point_x",   b_px,  m_px[1]);
        chk("b_point_y",   b_py,  m_py[1]);
        chk("b_pickup_p1", b_pk1, m_pk1[1]);
        chk("b_pickup_p2", b_pk2, m_pk2[1]);
        chk("b_score1",    b_s1,  m_s1[1]);
        chk("b_score2",    b_s2,  m_s2[1]);
    endtask

    task automatic cycle();
        model_step(0, ack_a);
        model_step(1, ack_b);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic spawn_at(input int x, input int y);
        spawn_x = 10'(x); spawn_y = 10'(y);
        ack_a = 1; ack_b = 1;
        cycle();
        ack_a = 0; ack_b = 0;
    endtask

    task automatic wait_req_a(output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!a_req && n < 100);
    endtask

    task automatic put_p1(input int x, input int y);
        player1_x = 10'(x); player1_y = 10'(y);
    endtask

    task automatic put_p2(input int x, input int y);
        player2_x = 10'(x); player2_y = 10'(y);
    endtask

    function automatic int near(input int c);
        int v;
        v = c + $urandom_range(0, 80) - 40;
        if (v < 0) v = 0;
        if (v > 1023) v = 1023;
        return v;
    endfunction

    initial begin
        int n, pulses;
        rst = 0; game_active = 0; score_clr = 0;
        put_p1(0, 0); put_p2(1000, 1000);
        spawn_x = 0; spawn_y = 0; ack_a = 0; ack_b = 0;

        cycle(); cycle();
        chk("rst_req", a_req, 0);
        chk("rst_visible", a_vis, 0);
        chk("rst_score1", a_s1, 0);

        rst = 1; game_active = 1;
        cycle();
        chk("start_req", a_req, 1);
        spawn_at(512, 64);
        chk("spawn_visible", a_vis, 1);
        chk("spawn_px", a_px, 512);
        chk("spawn_py", a_py, 64);

        put_p1(530, 70);
        cycle();
        chk("single_pk1", a_pk1, 1);
        chk("single_score1", a_s1, 1);
        chk("single_visible", a_vis, 0);
        put_p1(0, 0);
        wait_req_a(n);
        chk("cooldown_len", n, 32);

        spawn_at(512, 64);
        put_p1(537, 64);
        repeat (3) cycle();
        chk("miss_hi_score", a_s1, 1);
        put_p1(536, 64);
        cycle();
        chk("hit_hi_pk1", a_pk1, 1);
        chk("hit_hi_score", a_s1, 2);
        put_p1(0, 0);
        wait_req_a(n);
        spawn_at(512, 64);
        put_p1(487, 64);
        repeat (3) cycle();
        chk("miss_lo_score", a_s1, 2);
        put_p1(488, 64);
        cycle();
        chk("hit_lo_pk1", a_pk1, 1);
        chk("hit_lo_score", a_s1, 3);
        chk("b_sat_early", b_s1, 3);
        put_p1(0, 0);

        rst = 0; cycle(); rst = 1;
        cycle();
        spawn_at(512, 64);
        put_p1(512, 64); put_p2(512, 64);
        cycle();
        chk("tie1_pk1", a_pk1, 1);
        chk("tie1_pk2", a_pk2, 0);
        chk("tie1_score1", a_s1, 1);
        chk("tie1_score2", a_s2, 0);
        wait_req_a(n);
        spawn_at(512, 64);
        cycle();
        chk("tie2_pk1", a_pk1, 0);
        chk("tie2_pk2", a_pk2, 1);
        chk("tie2_score1", a_s1, 1);
        chk("tie2_score2", a_s2, 1);
        put_p1(0, 0); put_p2(1000, 1000);

        wait_req_a(n);
        for (int i = 0; i < 10; i++) begin
            cycle();
            chk("stall_req", a_req, 1);
        end
        game_active = 0;
        cycle();
        chk("abort_req", a_req, 0);
        chk("abort_hold_s1", a_s1, 1);
        chk("abort_hold_s2", a_s2, 1);
        score_clr = 1;
        cycle();
        score_clr = 0;
        chk("clr_s1", a_s1, 0);
        chk("clr_s2", a_s2, 0);

        game_active = 1;
        put_p1(300, 300);
        spawn_x = 300; spawn_y = 300; ack_b = 1; ack_a = 0;
        pulses = 0;
        repeat (20) begin
            cycle();
            if (b_pk1) pulses++;
        end
        ack_b = 0;
        chk("sat_score1", b_s1, 3);
        chk("sat_pulses", pulses, 9);

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 511) != 0);
            game_active = ($urandom_range(0, 63) != 0);
            score_clr   = ($urandom_range(0, 127) == 0);
            ack_a       = $urandom_range(0, 1);
            ack_b       = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) begin
                spawn_x = 10'($urandom_range(0, 20));
                spawn_y = 10'($urandom_range(1003, 1023));
            end else begin
                spawn_x = 10'($urandom_range(100, 900));
                spawn_y = 10'($urandom_range(100, 900));
            end
            if ($urandom_range(0, 1) == 1) put_p1(near(m_px[0]), near(m_py[0]));
            else put_p1($urandom_range(0, 1023), $urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) put_p2(near(m_px[1]), near(m_py[1]));
            else put_p2($urandom_range(0, 1023), $urandom_range(0, 1023));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
